// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   state_t   : receiver FSM states
//   bps_cnt() : sys_clk cycles per bit for a given clock/baud pair
//   half_cnt(): mid-bit sample offset for a given bit period
//   DATA_BITS : payload bits per frame (8N1)
//   STOP_IDX  : bit_cnt value of the stop bit
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_IDX  = 9;

  function automatic int unsigned bps_cnt(input int unsigned clk_freq,
                                          input int unsigned baud);
    return clk_freq / baud;
  endfunction

  function automatic int unsigned half_cnt(input int unsigned bit_cycles);
    return bit_cycles / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Three-flop synchroniser and falling-edge detector for the RX pin.
//   sys_clk   : system clock
//   sys_rst_n : asynchronous active-low reset (flops reset to idle-high)
//   uart_rxd  : raw asynchronous serial input
//   rxd_d1    : synchronised line level
//   fall      : one-cycle high on a synchronised high-to-low transition
module uart_rx_sync (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic uart_rxd,
  output logic rxd_d1,
  output logic fall
);

  logic rxd_d0;
  logic rxd_d2;

  // Reset to 1 so releasing reset on an idle line never looks like a start edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rxd_d0 <= 1'b1;
      rxd_d1 <= 1'b1;
      rxd_d2 <= 1'b1;
    end else begin
      rxd_d0 <= uart_rxd;
      rxd_d1 <= rxd_d0;
      rxd_d2 <= rxd_d1;
    end
  end

  assign fall = rxd_d2 & ~rxd_d1;

endmodule

// File: rtl/uart_recv.sv
// UART receiver, 8N1, LSB first, majority-of-three mid-bit sampling.
//   sys_clk   : system clock
//   sys_rst_n : asynchronous active-low reset
//   uart_rxd  : asynchronous serial input, idle high
//   uart_data : last correctly framed byte, held until the next good byte
//   uart_done : one-cycle pulse, uart_data valid in the same cycle
//   frame_err : one-cycle pulse when the stop bit samples low
//   rx_busy   : high whenever the receiver is not idle
module uart_recv
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned UART_BPS = 115200
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_rxd,
  output logic [7:0] uart_data,
  output logic       uart_done,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int unsigned BPS_CNT = bps_cnt(CLK_FREQ, UART_BPS);
  localparam int unsigned HALF    = half_cnt(BPS_CNT);

  localparam logic [15:0] CNT_LAST   = 16'(BPS_CNT - 1);
  localparam logic [15:0] CNT_SAMP0  = 16'(HALF - 1);
  localparam logic [15:0] CNT_SAMP1  = 16'(HALF);
  localparam logic [15:0] CNT_DECIDE = 16'(HALF + 1);
  localparam logic [3:0]  LAST_DATA  = 4'(STOP_IDX - 1);

  state_t      state, state_d;
  logic        rxd_d1, fall;
  logic [15:0] clk_cnt;
  logic [3:0]  bit_cnt;
  logic        samp0, samp1;
  logic [7:0]  shift_reg;
  logic        last_tick, decide, maj;
  logic        done_d, err_d;

  uart_rx_sync u_sync (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .uart_rxd  (uart_rxd),
    .rxd_d1    (rxd_d1),
    .fall      (fall)
  );

  assign last_tick = (clk_cnt == CNT_LAST);
  assign decide    = (clk_cnt == CNT_DECIDE);
  assign maj       = (samp0 & samp1) | (samp0 & rxd_d1) | (samp1 & rxd_d1);
  assign rx_busy   = (state != IDLE);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_d;
  end

  always_comb begin
    state_d = state;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state)
      IDLE:  if (fall) state_d = START;
      START: begin
        if (decide && maj)  state_d = IDLE;
        else if (last_tick) state_d = DATA;
      end
      DATA:  if (last_tick && bit_cnt == LAST_DATA) state_d = STOP;
      STOP: begin
        // Leave at the mid-bit decision so a start edge in the second half
        // of the stop bit is still caught.
        if (decide) begin
          if (maj) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = BREAK;
            err_d   = 1'b1;
          end
        end
      end
      BREAK: if (rxd_d1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      samp0     <= 1'b0;
      samp1     <= 1'b0;
      shift_reg <= '0;
      uart_data <= '0;
      uart_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      uart_done <= done_d;
      frame_err <= err_d;
      if (done_d) uart_data <= shift_reg;

      if (state == IDLE || state == BREAK) begin
        clk_cnt <= '0;
        bit_cnt <= '0;
      end else if (last_tick) begin
        clk_cnt <= '0;
        bit_cnt <= bit_cnt + 4'd1;
      end else begin
        clk_cnt <= clk_cnt + 16'd1;
      end

      if (clk_cnt == CNT_SAMP0) samp0 <= rxd_d1;
      if (clk_cnt == CNT_SAMP1) samp1 <= rxd_d1;

      if (state == DATA && decide) shift_reg <= {maj, shift_reg[7:1]};
    end
  end

endmodule
